layer1_leaky_relu: RTL

//  Activation stage directly downstream of the GAN generator layer-1 dense MAC.
//  - Consumes its 256 x Q8.8 flat output bus on a start pulse.
//  - Applies LeakyReLU serially, one element per clock.
//  - Presents the activated vector on a flat bus with a one-cycle done pulse.
//  - Feeds the layer-2 dense stage; shares its start/done pulse protocol.

---
 rtl/layer1_leaky_relu_if.sv | 28 ++
 rtl/layer1_leaky_relu.sv | 111 +++++++++++
 2 files changed

// File: rtl/layer1_leaky_relu_if.sv
// Start/done handshake and flat vector buses between the layer-1 dense MAC,
// the LeakyReLU activation stage and the layer-2 dense stage.
interface layer1_leaky_relu_if #(
    parameter int N_ELEM = 256,
    parameter int DATA_W = 16
);
    logic                     start;
    logic [DATA_W*N_ELEM-1:0] flat_input_flat;
    logic [DATA_W*N_ELEM-1:0] flat_output_flat;
    logic                     busy;
    logic                     done;

    modport master (
        output start,
        output flat_input_flat,
        input  flat_output_flat,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  flat_input_flat,
        output flat_output_flat,
        output busy,
        output done
    );
endinterface

// File: rtl/layer1_leaky_relu.sv
// LeakyReLU activation stage for the GAN generator layer-1 output vector.
// Captures the input vector on start, then activates one element per clock.
// Optional build macro GAN_L1ACT_CLAMP_EN clamps positive results to CLAMP_MAX.
module layer1_leaky_relu #(
    parameter int N_ELEM      = 256,
    parameter int DATA_W      = 16,
    parameter int SLOPE_SHIFT = 3
`ifdef GAN_L1ACT_CLAMP_EN
    ,
    parameter logic signed [DATA_W-1:0] CLAMP_MAX = 16'sh0600
`endif
) (
    input  logic              clk,
    input  logic              rst,
    layer1_leaky_relu_if.slave bus
);

    localparam int                IDX_W = $clog2(N_ELEM);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_ELEM - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                          state;
    state_t                          next_state;
    logic [IDX_W-1:0]                idx;
    logic [N_ELEM-1:0][DATA_W-1:0]   shadow;
    logic [N_ELEM-1:0][DATA_W-1:0]   out_r;
    logic                            busy_r;
    logic                            done_r;
    logic                            capture;

    // LeakyReLU on one signed element; negative slope is an arithmetic shift.
    function automatic logic signed [DATA_W-1:0] act(input logic signed [DATA_W-1:0] x);
        if (x[DATA_W-1]) begin
            act = x >>> SLOPE_SHIFT;
        end else begin
`ifdef GAN_L1ACT_CLAMP_EN
            act = (x > CLAMP_MAX) ? CLAMP_MAX : x;
`else
            act = x;
`endif
        end
    endfunction

    assign capture              = (state == IDLE) && bus.start;
    assign bus.flat_output_flat = out_r;
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: start launches a run, the last element ends it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.start) next_state = RUN;
            RUN:  if (idx == LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Shadow copy of the input so upstream may move on after the start cycle.
    always_ff @(posedge clk) begin
        if (capture) begin
            shadow <= bus.flat_input_flat;
        end
    end

    // Element counter, serial output write-back and busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r  <= '0;
            idx    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                RUN: begin
                    out_r[idx] <= act(shadow[idx]);
                    if (idx == LAST) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
